// File: rtl/input_pkg.sv
// input_pkg -- shared types and default timing for the push-button front end.
// Optional diagnostics are enabled by defining BTN_DEBOUNCE_DIAG_EN.
package input_pkg;

  // Per-button auto-repeat state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DAS    = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } chan_state_t;

  // Button indices on the KEY bus
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_ROTATE = 2;
  localparam int BTN_DROP   = 3;

  // Default timing, in 100 Hz ticks
  localparam int         DEF_NUM_BTN      = 4;
  localparam int         DEF_STABLE_TICKS = 3;   // 30 ms
  localparam int         DEF_DAS_DELAY    = 20;  // 200 ms
  localparam int         DEF_ARR_PERIOD   = 5;   // 50 ms
  localparam logic [3:0] DEF_REPEAT_MASK  = 4'b0011;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel -- one button: 2-flop synchronizer, tick-based debounce and
// delayed-auto-shift repeat FSM. With BTN_DEBOUNCE_DIAG_EN defined an extra
// 'glitch' output flags ticks where a partial bounce run was discarded.
module btn_channel
  import input_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int DAS_DELAY    = DEF_DAS_DELAY,
  parameter int ARR_PERIOD   = DEF_ARR_PERIOD
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic tick_input,
  input  logic repeat_en,
  input  logic btn_raw_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_move
`ifdef BTN_DEBOUNCE_DIAG_EN
  ,
  output logic glitch
`endif
);

  localparam int STAB_W = $clog2(STABLE_TICKS + 1);
  localparam int REP_W  = $clog2(max2(DAS_DELAY, ARR_PERIOD) + 1);

  logic              sync_meta_reg;
  logic              sync_reg;
  logic              sync;
  logic              level_reg;
  logic [STAB_W-1:0] stab_cnt_reg;
  logic              disagree;
  logic              stab_full;
  logic              level_rise;
  logic              level_fall;

  chan_state_t       state_reg, state_next;
  logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
  logic              press_reg, press_next;
  logic              move_reg, move_next;
  logic              das_done;
  logic              arr_done;

  // Two-flop synchronizer; resets to "released"
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_meta_reg <= 1'b1;
      sync_reg      <= 1'b1;
    end else begin
      sync_meta_reg <= btn_raw_n;
      sync_reg      <= sync_meta_reg;
    end
  end

  assign sync      = ~sync_reg;
  assign disagree  = (sync != level_reg);
  assign stab_full = (stab_cnt_reg == STAB_W'(STABLE_TICKS - 1));
  // The level flips on the tick that completes the disagreement run
  assign level_rise = tick_input && disagree && stab_full && !level_reg;
  assign level_fall = tick_input && disagree && stab_full &&  level_reg;

  // Debounce: count consecutive disagreeing ticks, flip level when the run is long enough
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      level_reg    <= 1'b0;
      stab_cnt_reg <= '0;
    end else if (tick_input) begin
      if (disagree) begin
        if (stab_full) begin
          level_reg    <= ~level_reg;
          stab_cnt_reg <= '0;
        end else begin
          stab_cnt_reg <= stab_cnt_reg + 1'b1;
        end
      end else begin
        stab_cnt_reg <= '0;
      end
    end
  end

  assign das_done = (rep_cnt_reg == REP_W'(DAS_DELAY - 1));
  assign arr_done = (rep_cnt_reg == REP_W'(ARR_PERIOD - 1));

  // FSM state register; pulse outputs are registered alongside it
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg   <= IDLE;
      rep_cnt_reg <= '0;
      press_reg   <= 1'b0;
      move_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rep_cnt_reg <= rep_cnt_next;
      press_reg   <= press_next;
      move_reg    <= move_next;
    end
  end

  // FSM next state: a falling level always wins over a pending repeat
  always_comb begin
    state_next   = state_reg;
    rep_cnt_next = rep_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (level_rise) begin
          state_next   = repeat_en ? DAS : HELD;
          rep_cnt_next = '0;
        end
      end
      DAS: begin
        if (level_fall) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end else if (tick_input) begin
          if (das_done) begin
            state_next   = REPEAT;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (level_fall) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end else if (tick_input) begin
          rep_cnt_next = arr_done ? '0 : rep_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (level_fall) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        rep_cnt_next = '0;
      end
    endcase
  end

  // FSM outputs: press on the rise, move on the rise and on each repeat expiry
  always_comb begin
    press_next = (state_reg == IDLE) && level_rise;
    move_next  = press_next ||
                 (tick_input && !level_fall &&
                  (((state_reg == DAS) && das_done) ||
                   ((state_reg == REPEAT) && arr_done)));
  end

  assign btn_level = level_reg;
  assign btn_press = press_reg;
  assign btn_move  = move_reg;

`ifdef BTN_DEBOUNCE_DIAG_EN
  // A partial run thrown away on agreement is a rejected bounce
  assign glitch = tick_input && !disagree && (stab_cnt_reg != '0);
`endif

endmodule

// File: rtl/btn_debounce_repeat.sv
// btn_debounce_repeat -- debounced levels, press strobes and DAS auto-repeat
// move strobes for the DE1-SoC KEY buttons. Define BTN_DEBOUNCE_DIAG_EN to add
// the saturating 16-bit glitch_cnt output counting rejected bounces.
module btn_debounce_repeat
  import input_pkg::*;
#(
  parameter int                 NUM_BTN      = DEF_NUM_BTN,
  parameter int                 STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int                 DAS_DELAY    = DEF_DAS_DELAY,
  parameter int                 ARR_PERIOD   = DEF_ARR_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK  = DEF_REPEAT_MASK
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               tick_input,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_move
`ifdef BTN_DEBOUNCE_DIAG_EN
  ,
  output logic [15:0]        glitch_cnt
`endif
);

`ifdef BTN_DEBOUNCE_DIAG_EN
  logic [NUM_BTN-1:0] glitch_vec;
  logic [15:0]        glitch_cnt_reg;
`endif

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .DAS_DELAY    (DAS_DELAY),
      .ARR_PERIOD   (ARR_PERIOD)
    ) u_chan (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .tick_input (tick_input),
      .repeat_en  (REPEAT_MASK[gi]),
      .btn_raw_n  (btn_raw_n[gi]),
      .btn_level  (btn_level[gi]),
      .btn_press  (btn_press[gi]),
      .btn_move   (btn_move[gi])
`ifdef BTN_DEBOUNCE_DIAG_EN
      ,
      .glitch     (glitch_vec[gi])
`endif
    );
  end

`ifdef BTN_DEBOUNCE_DIAG_EN
  // One count per tick with any rejected bounce, saturating at all-ones
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      glitch_cnt_reg <= '0;
    end else if ((|glitch_vec) && (glitch_cnt_reg != 16'hFFFF)) begin
      glitch_cnt_reg <= glitch_cnt_reg + 16'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_reg;
`endif

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// tb_btn_debounce_repeat -- table vectors, directed DAS/ARR sequences and a
// randomized run against a tick-history reference model.
module tb_btn_debounce_repeat;
  import input_pkg::*;

  localparam int         NB    = 4;
  localparam int         ST    = 3;
  localparam int         DASD  = 20;
  localparam int         ARRP  = 5;
  localparam logic [3:0] MASKP = 4'b0011;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       tick_input = 1'b0;
  logic [3:0] btn_raw_n = 4'hF;
  logic [3:0] btn_level, btn_press, btn_move;
`ifdef BTN_DEBOUNCE_DIAG_EN
  logic [15:0] glitch_cnt;
`endif

  btn_debounce_repeat dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick_input (tick_input),
    .btn_raw_n  (btn_raw_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_move   (btn_move)
`ifdef BTN_DEBOUNCE_DIAG_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw history, agreement runs, ticks held since press
  logic [3:0] hist_q[$];
  logic [3:0] mask_v;
  int         run_m[NB];
  logic [3:0] lvl_m;
  int         held_m[NB];
  int         glitch_m;
  logic [3:0] press_m, move_m;

  // Observation bookkeeping for directed sequences
  int tick_no;
  int press_cnt[NB];
  int move_cnt[NB];
  int press_tick[NB];
  int move_tick_q[$];
  int lvl2_drop;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    hist_q = {};
    hist_q.push_back(4'hF);
    hist_q.push_back(4'hF);
    lvl_m = '0; press_m = '0; move_m = '0; glitch_m = 0;
    for (int i = 0; i < NB; i++) begin
      run_m[i] = 0; held_m[i] = 0;
    end
  endtask

  task automatic model_step(input logic rst, input logic tk, input logic [3:0] raw);
    logic [3:0] pressed;
    logic any_g, rose, fell;
    if (rst) begin
      model_reset();
      return;
    end
    pressed = ~hist_q[0];
    hist_q.push_back(raw);
    void'(hist_q.pop_front());
    press_m = '0; move_m = '0; any_g = 1'b0;
    if (tk) begin
      for (int i = 0; i < NB; i++) begin
        rose = 1'b0; fell = 1'b0;
        if (pressed[i] != lvl_m[i]) begin
          run_m[i]++;
          if (run_m[i] == ST) begin
            run_m[i] = 0;
            if (lvl_m[i]) fell = 1'b1; else rose = 1'b1;
            lvl_m[i] = ~lvl_m[i];
          end
        end else begin
          if (run_m[i] != 0) any_g = 1'b1;
          run_m[i] = 0;
        end
        if (rose) begin
          held_m[i] = 0; press_m[i] = 1'b1; move_m[i] = 1'b1;
        end else if (lvl_m[i] && !fell) begin
          held_m[i]++;
          if (mask_v[i] && (held_m[i] == DASD ||
              (held_m[i] > DASD && (held_m[i] - DASD) % ARRP == 0)))
            move_m[i] = 1'b1;
        end
      end
      if (any_g && glitch_m < 65535) glitch_m++;
    end
  endtask

  // One clock: drive, step the model on the edge, compare 1 time unit later
  task automatic cycle(input logic rst, input logic tk, input logic [3:0] raw);
    reset = rst; tick_input = tk; btn_raw_n = raw;
    @(posedge CLOCK_50);
    model_step(rst, tk, raw);
    if (tk && !rst) tick_no++;
    #1;
    chk("model_level", 16'(btn_level), 16'(lvl_m));
    chk("model_press", 16'(btn_press), 16'(press_m));
    chk("model_move", 16'(btn_move), 16'(move_m));
`ifdef BTN_DEBOUNCE_DIAG_EN
    chk("model_glitch", glitch_cnt, 16'(glitch_m));
`endif
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i]) begin press_cnt[i]++; press_tick[i] = tick_no; end
      if (btn_move[i]) move_cnt[i]++;
    end
    if (btn_move[0]) move_tick_q.push_back(tick_no);
    if (press_cnt[2] > 0 && !btn_level[2]) lvl2_drop++;
  endtask

  // n ticks, each preceded by per-1 idle cycles
  task automatic ticks(input logic [3:0] raw, input int n, input int per);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < per - 1; c++) cycle(1'b0, 1'b0, raw);
      cycle(1'b0, 1'b1, raw);
    end
  endtask

  task automatic clear_obs();
    tick_no = 0; lvl2_drop = 0; move_tick_q = {};
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; move_cnt[i] = 0; press_tick[i] = -1;
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 4'hF);
    clear_obs();
  endtask

  typedef struct {
    logic       rst;
    logic       tk;
    logic [3:0] raw;
    logic [3:0] e_lvl;
    logic [3:0] e_prs;
    logic [3:0] e_mov;
  } vec_t;

  vec_t vt[8];

  initial begin
    int waited;
    logic [3:0] rr;
    mask_v = MASKP;
    model_reset();
    clear_obs();

    // Reset with all buttons held, then continuous ticks
    vt[0] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[1] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[2] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[3] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[4] = '{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    vt[5] = '{1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 4'hF};
    vt[6] = '{1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0};
    vt[7] = '{1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'h0};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      cycle(vt[v].rst, vt[v].tk, vt[v].raw);
      chk($sformatf("tbl%0d_level", v), 16'(btn_level), 16'(vt[v].e_lvl));
      chk($sformatf("tbl%0d_press", v), 16'(btn_press), 16'(vt[v].e_prs));
      chk($sformatf("tbl%0d_move", v), 16'(btn_move), 16'(vt[v].e_mov));
    end
    for (int i = 0; i < NB; i++) chk($sformatf("tbl_press_once%0d", i), 16'(press_cnt[i]), 16'd1);
    $display("table: startup vectors applied");

    // Bounce rejection on rotate
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ticks(4'b1011, 1, 4);
      ticks(4'b1111, 1, 4);
    end
    chk("bounce_level2", 16'(btn_level[2]), 16'd0);
    chk("bounce_press2", 16'(press_cnt[2]), 16'd0);
    chk("bounce_move2", 16'(move_cnt[2]), 16'd0);
`ifdef BTN_DEBOUNCE_DIAG_EN
    chk("bounce_glitch_nonzero", 16'(glitch_cnt != 0), 16'd1);
`endif
    $display("seq: bounce rejection done");

    // Auto-repeat on left: 40 ticks held, then release
    do_reset();
    ticks(4'b1110, 40, 4);
    ticks(4'b1111, 6, 4);
    chk("rep_press_cnt", 16'(press_cnt[0]), 16'd1);
    chk("rep_move_cnt", 16'(move_cnt[0]), 16'd5);
    if (move_tick_q.size() == 5) begin
      chk("rep_off1", 16'(move_tick_q[1] - move_tick_q[0]), 16'd20);
      chk("rep_off2", 16'(move_tick_q[2] - move_tick_q[0]), 16'd25);
      chk("rep_off3", 16'(move_tick_q[3] - move_tick_q[0]), 16'd30);
      chk("rep_off4", 16'(move_tick_q[4] - move_tick_q[0]), 16'd35);
    end
    chk("rep_first_is_press", 16'(move_tick_q.size() > 0 && move_tick_q[0] == press_tick[0]), 16'd1);
    chk("rep_released", 16'(btn_level[0]), 16'd0);
    $display("seq: auto-repeat done");

    // Masked rotate: no repeats, level held throughout
    do_reset();
    ticks(4'b1011, 40, 4);
    chk("mask_press_cnt", 16'(press_cnt[2]), 16'd1);
    chk("mask_move_cnt", 16'(move_cnt[2]), 16'd1);
    chk("mask_level_drop", 16'(lvl2_drop), 16'd0);
    chk("mask_level", 16'(btn_level[2]), 16'd1);
    $display("seq: masked rotate done");

    // Release race: level falls on press tick + 20
    do_reset();
    ticks(4'b1110, 20, 4);
    ticks(4'b1111, 6, 4);
    chk("race_press_tick", 16'(press_tick[0]), 16'd3);
    chk("race_move_cnt", 16'(move_cnt[0]), 16'd1);
    chk("race_level", 16'(btn_level[0]), 16'd0);
    ticks(4'b1110, 4, 4);
    chk("race_repress", 16'(press_cnt[0]), 16'd2);
    $display("seq: release race done");

    // Reset while right is repeating
    do_reset();
    ticks(4'b1101, 30, 4);
    chk("mid_repeating", 16'(move_cnt[1] >= 2), 16'd1);
    cycle(1'b1, 1'b0, 4'b1101);
    chk("mid_rst_level", 16'(btn_level), 16'd0);
    chk("mid_rst_press", 16'(btn_press), 16'd0);
    chk("mid_rst_move", 16'(btn_move), 16'd0);
    waited = 0;
    while (!btn_press[1] && waited < 20) begin
      cycle(1'b0, 1'b1, 4'b1101);
      waited++;
    end
    chk("mid_repress_cycles", 16'(waited), 16'd5);
    $display("seq: reset mid-repeat done");

    // Randomized: slow bouncy buttons, irregular ticks, rare resets
    do_reset();
    rr = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 29) == 0) rr[i] = ~rr[i];
      cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 2) == 0), rr);
    end
    $display("random: 4000 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
